// File: rtl/down_count_pkg.sv
// down_count_pkg: state encoding and default width shared by the down-counter controller
package down_count_pkg;
  localparam int WIDTH_DEF = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/down_counter_core.sv
// down_counter_core: synchronous loadable down-counter that stops at zero
// ports: clock, reset (sync, active-high), load/load_data, en -> count, zero
module down_counter_core
  import down_count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count,
  output logic             zero
);
  assign zero = count == '0;
  always_ff @(posedge clock)
    if (reset) count <= '0;
    else if (load) count <= load_data;
    else if (en && !zero) count <= count - WIDTH'(1);
endmodule

// File: rtl/down_count_ctrl.sv
// down_count_ctrl: start/stop/pause sequencer with one-shot and auto-reload modes around a down-counter
// ports: clock, reset (sync, active-high), start, stop, pause, load_val, auto_reload
//        -> count, state (IDLE/RUN/HOLD/DONE), busy, tc (one-cycle pulse at zero), done
module down_count_ctrl
  import down_count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  logic [WIDTH-1:0] reload_reg, load_data;
  logic [1:0] next_state;
  logic mode, load, en, zero, one, run_go, tc_next;
  down_counter_core #(.WIDTH(WIDTH)) core (
    .clock(clock), .reset(reset), .load(load), .en(en),
    .load_data(load_data), .count(count), .zero(zero)
  );
  assign one = count == WIDTH'(1);
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      tc <= 1'b0;
      reload_reg <= '0;
      mode <= 1'b0;
    end else begin
      state <= next_state;
      tc <= tc_next;
      if (start && !stop) begin
        reload_reg <= load_val;
        mode <= auto_reload;
      end
    end
  always_comb
    next_state = stop ? IDLE :
                 start ? (load_val == '0 ? DONE : RUN) :
                 state == RUN ? (pause ? HOLD : (one && !mode ? DONE : RUN)) :
                 state == HOLD ? (pause ? HOLD : RUN) : state;
  // Auto-reload spends the zero cycle in RUN and reloads on the following edge.
  // A zero-value start lands in DONE, so reload_reg is never zero while reloading.
  always_comb begin
    run_go = state == RUN && !pause;
    load = stop || start || (run_go && zero && mode);
    load_data = stop ? '0 : start ? load_val : reload_reg;
    en = run_go;
    tc_next = !stop && (start ? load_val == '0 : run_go && one);
    busy = state == RUN || state == HOLD;
    done = state == DONE;
  end
endmodule

// File: tb/tb_down_count_ctrl.sv
// tb_down_count_ctrl: directed scoreboard bench for down_count_ctrl
module tb_down_count_ctrl;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0, auto_reload = 1'b0;
  logic [3:0] load_val = '0, count;
  logic [1:0] state;
  logic busy, tc, done;
  typedef struct packed {logic [3:0] count; logic [1:0] state; logic busy, tc, done;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, tc_seen = 0, n;
  string phase = "reset";
  logic [3:0] m_count = '0, m_reload = '0;
  logic [1:0] m_state = 2'd0;
  logic m_mode = 1'b0, m_tc = 1'b0;

  down_count_ctrl #(.WIDTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .load_val(load_val), .auto_reload(auto_reload), .count(count), .state(state),
    .busy(busy), .tc(tc), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, s, st, p, input logic [3:0] lv, input logic ar);
    m_tc = 1'b0;
    if (r) begin
      m_state = 2'd0; m_count = '0; m_reload = '0; m_mode = 1'b0;
    end else if (st) begin
      m_state = 2'd0; m_count = '0;
    end else if (s) begin
      m_reload = lv; m_mode = ar; m_count = lv;
      if (lv == 0) begin m_state = 2'd3; m_tc = 1'b1; end
      else m_state = 2'd1;
    end else if (m_state == 2'd1) begin
      if (p) m_state = 2'd2;
      else if (m_count == 0) m_count = m_reload;
      else begin
        m_count = m_count - 4'd1;
        m_tc = m_count == 0;
        if (m_tc && !m_mode) m_state = 2'd3;
      end
    end else if (m_state == 2'd2 && !p) m_state = 2'd1;
  endtask

  task automatic step(input logic r, s, st, p, input logic [3:0] lv, input logic ar);
    exp_t e;
    reset = r; start = s; stop = st; pause = p; load_val = lv; auto_reload = ar;
    model(r, s, st, p, lv, ar);
    q.push_back('{m_count, m_state, m_state == 2'd1 || m_state == 2'd2, m_tc, m_state == 2'd3});
    @(posedge clock);
    #1;
    e = q.pop_front();
    if (tc === 1'b1) tc_seen++;
    check("count", 32'(count), 32'(e.count));
    check("state", 32'(state), 32'(e.state));
    check("busy", 32'(busy), 32'(e.busy));
    check("tc", 32'(tc), 32'(e.tc));
    check("done", 32'(done), 32'(e.done));
  endtask

  task automatic idle(input int k, input logic p);
    for (int i = 0; i < k; i++) step(0, 0, 0, p, 4'($urandom), 1'($urandom));
  endtask

  initial begin
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
    check("reset_count", 32'(count), 0);
    check("reset_state", 32'(state), 0);
    idle(1, 0);

    phase = "oneshot";
    step(0, 1, 0, 0, 4'd5, 0);
    check("start_val", 32'(count), 5);
    tc_seen = 0;
    idle(5, 0);
    check("done_state", 32'(state), 3);
    check("done_tc_count", tc_seen, 1);
    idle(2, 0);
    check("done_hold", 32'(done), 1);

    phase = "autoreload";
    step(0, 1, 0, 0, 4'd3, 1);
    tc_seen = 0;
    idle(12, 0);
    check("auto_tc_count", tc_seen, 3);
    step(0, 0, 1, 0, 4'd3, 1);
    check("stop_state", 32'(state), 0);

    phase = "pause";
    step(0, 1, 0, 0, 4'd9, 0);
    idle(3, 0);
    check("pre_pause", 32'(count), 6);
    idle(3, 1);
    check("hold_state", 32'(state), 2);
    check("hold_count", 32'(count), 6);
    idle(7, 0);
    check("pause_done", 32'(state), 3);

    phase = "conflict";
    step(0, 1, 0, 0, 4'd7, 0);
    idle(3, 0);
    step(0, 1, 1, 0, 4'd12, 0);
    check("stop_wins", 32'(count), 0);
    step(0, 1, 0, 0, 4'd7, 0);
    idle(3, 0);
    step(0, 1, 0, 0, 4'd12, 0);
    check("restart", 32'(count), 12);
    idle(2, 1);
    step(0, 1, 0, 1, 4'd2, 0);
    idle(3, 0);

    phase = "boundary";
    step(0, 1, 0, 0, 4'd0, 1);
    check("zero_tc", 32'(tc), 1);
    idle(2, 0);
    step(0, 1, 0, 0, 4'd15, 0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 0, 0, 4'd0, 0);
      if (tc === 1'b1) begin n = i; break; end
    end
    check("max_latency", n, 15);
    idle(2, 0);
    step(0, 1, 0, 0, 4'd9, 0);
    idle(2, 0);
    step(1, 1, 0, 0, 4'd4, 1);
    check("midrun_reset", 32'(count), 0);
    idle(2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
